// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: redirect input, instruction-memory req/ack port and decode valid/ready port.
interface fetch_queue_if #(
    parameter int WIDTH = 16
);
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_rdata;
    logic             inst_valid;
    logic             inst_ready;
    logic [WIDTH-1:0] inst;
    logic [WIDTH-1:0] inst_pc;
    logic [WIDTH-1:0] inst_seq_pc;

    modport master (
        input  redirect, redirect_pc, imem_ack, imem_rdata, inst_ready,
        output imem_req, imem_addr, inst_valid, inst, inst_pc, inst_seq_pc
    );

    modport slave (
        output redirect, redirect_pc, imem_ack, imem_rdata, inst_ready,
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, inst_seq_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Fetch stage: one outstanding imem read at a time, responses queued with their PC for decode.
// Define FETCH_BYPASS_EN to forward an accepted response straight to decode when the queue is empty.
//
// state | meaning
// IDLE  | may issue a read at fetch_pc when the queue has room
// WAIT  | read outstanding, response will be queued
// DROP  | read outstanding but flushed by a redirect, response discarded
module fetch_queue #(
    parameter int unsigned      WIDTH    = 16,
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      INC      = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          rst,
    fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] req_pc;
    logic [CW-1:0]    count;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [WIDTH-1:0] mem_inst [DEPTH];
    logic [WIDTH-1:0] mem_pc   [DEPTH];

    logic             issue;
    logic             accept;
    logic             push;
    logic             pop;
    logic             bypass_hit;
    logic             not_empty;
    logic [WIDTH-1:0] head_pc;

    assign not_empty = (count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (issue) state_nxt = WAIT;
            WAIT: begin
                if (bus.imem_ack)     state_nxt = IDLE;
                else if (bus.redirect) state_nxt = DROP;
            end
            DROP: if (bus.imem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rst gates issue so imem_req drops immediately on an asynchronous reset
    always_comb begin
        issue  = 1'b0;
        accept = 1'b0;
        case (state)
            IDLE:    issue  = rst && (count < CW'(DEPTH)) && !bus.redirect;
            WAIT:    accept = bus.imem_ack && !bus.redirect;
            default: ;
        endcase
    end

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = accept && !not_empty;
`else
    assign bypass_hit = 1'b0;
`endif

    // a bypassed response that decode takes in the same cycle never enters the queue
    assign push = accept && !(bypass_hit && bus.inst_ready);
    assign pop  = not_empty && bus.inst_ready && !bus.redirect;

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fetch_pc;
    assign bus.inst_valid  = rst && (not_empty || bypass_hit);
    assign bus.inst        = bypass_hit ? bus.imem_rdata : mem_inst[rd_ptr];
    assign head_pc         = bypass_hit ? req_pc : mem_pc[rd_ptr];
    assign bus.inst_pc     = head_pc;
    assign bus.inst_seq_pc = head_pc + WIDTH'(INC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (issue) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + WIDTH'(INC);
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr] <= bus.imem_rdata;
            mem_pc[wr_ptr]   <= req_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: stimulus table, directed corner sequences and a random run against a queue model.
module tb_fetch_queue;
    logic clk;
    logic rst;

    fetch_queue_if #(.WIDTH(16)) bus ();
    fetch_queue_if #(.WIDTH(16)) bus2 ();

    fetch_queue #(.WIDTH(16), .DEPTH(4), .INC(2), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    fetch_queue #(.WIDTH(16), .DEPTH(4), .INC(2), .RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        redirect;
        logic [15:0] rpc;
        logic        ack;
        logic [15:0] rdata;
        logic        ready;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_inst;
        logic [15:0] e_pc;
        logic [15:0] e_seq;
    } vec_t;

    typedef struct {
        logic [15:0] inst;
        logic [15:0] pc;
    } ent_t;

    int vectors     = 0;
    int miscompares = 0;

    logic        pend;
    logic [15:0] pend_addr;
    logic [15:0] req_log [$];

    function automatic vec_t mk(input int rd, input int rpc, input int ack, input int rdata,
                                input int rdy, input int ereq, input int eaddr, input int evalid,
                                input int einst, input int epc, input int eseq);
        vec_t v;
        v.redirect = 1'(rd);     v.rpc     = 16'(rpc);
        v.ack      = 1'(ack);    v.rdata   = 16'(rdata);
        v.ready    = 1'(rdy);    v.e_req   = 1'(ereq);
        v.e_addr   = 16'(eaddr); v.e_valid = 1'(evalid);
        v.e_inst   = 16'(einst); v.e_pc    = 16'(epc);
        v.e_seq    = 16'(eseq);
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        bus.redirect = 1'b0;  bus.redirect_pc = '0; bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;  bus.inst_ready = 1'b0;
        bus2.redirect = 1'b0; bus2.redirect_pc = '0; bus2.imem_ack = 1'b0;
        bus2.imem_rdata = '0; bus2.inst_ready = 1'b1;
    endtask

    // leaves time at posedge+1 of the first cycle after reset release
    task automatic do_reset();
        quiet_inputs();
        rst = 1'b0;
        pend = 1'b0;
        req_log.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // zero-wait memory: ack the cycle after each request, data = 0xA000 | address
    task automatic serve(input int n);
        for (int i = 0; i < n; i++) begin
            bus.imem_ack   = pend;
            bus.imem_rdata = 16'hA000 | pend_addr;
            #1;
            if (bus.imem_req) begin
                pend = 1'b1;
                pend_addr = bus.imem_addr;
                req_log.push_back(bus.imem_addr);
            end else begin
                pend = 1'b0;
            end
            tick();
        end
        bus.imem_ack = 1'b0;
    endtask

    vec_t tbl [12];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        ent_t        mq [$];
        logic [15:0] m_fpc;
        logic [15:0] m_opc;
        int          m_out;
        int          wcnt;
        logic        e_req;
        logic        e_valid;
        logic        seen;

        tbl[0]  = mk(0, 0,      0, 0,      1, 1, 'h0000, 0, 0,      0,      0);
        tbl[1]  = mk(0, 0,      1, 'h1111, 1, 0, 0,      0, 0,      0,      0);
        tbl[2]  = mk(0, 0,      0, 0,      1, 1, 'h0002, 1, 'h1111, 'h0000, 'h0002);
        tbl[3]  = mk(0, 0,      1, 'h2222, 1, 0, 0,      0, 0,      0,      0);
        tbl[4]  = mk(0, 0,      0, 0,      1, 1, 'h0004, 1, 'h2222, 'h0002, 'h0004);
        tbl[5]  = mk(1, 'h0100, 0, 0,      1, 0, 0,      0, 0,      0,      0);
        tbl[6]  = mk(0, 0,      0, 0,      1, 0, 0,      0, 0,      0,      0);
        tbl[7]  = mk(0, 0,      0, 0,      1, 0, 0,      0, 0,      0,      0);
        tbl[8]  = mk(0, 0,      1, 'hDEAD, 1, 0, 0,      0, 0,      0,      0);
        tbl[9]  = mk(0, 0,      0, 0,      1, 1, 'h0100, 0, 0,      0,      0);
        tbl[10] = mk(0, 0,      1, 'hBEEF, 1, 0, 0,      0, 0,      0,      0);
        tbl[11] = mk(0, 0,      0, 0,      1, 1, 'h0102, 1, 'hBEEF, 'h0100, 'h0102);

        // reset values observed while rst is low
        quiet_inputs();
        rst = 1'b0;
        #3;
        chk("reset_req", 16'(bus.imem_req), 16'd0);
        chk("reset_valid", 16'(bus.inst_valid), 16'd0);

        // table: sequential fetch, then redirect during WAIT with a late 0xDEAD response
        do_reset();
        for (int i = 0; i < 12; i++) begin
            bus.redirect    = tbl[i].redirect;
            bus.redirect_pc = tbl[i].rpc;
            bus.imem_ack    = tbl[i].ack;
            bus.imem_rdata  = tbl[i].rdata;
            bus.inst_ready  = tbl[i].ready;
            #1;
            chk($sformatf("tbl%0d_req", i), 16'(bus.imem_req), 16'(tbl[i].e_req));
            if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), bus.imem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), 16'(bus.inst_valid), 16'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_inst", i), bus.inst, tbl[i].e_inst);
                chk($sformatf("tbl%0d_pc", i), bus.inst_pc, tbl[i].e_pc);
                chk($sformatf("tbl%0d_seq", i), bus.inst_seq_pc, tbl[i].e_seq);
            end
            tick();
        end

        // backpressure: exactly DEPTH requests, then drain in order and resume at 0x0008
        do_reset();
        bus.inst_ready = 1'b0;
        serve(16);
        chk("bp_nreq", 16'(req_log.size()), 16'd4);
        for (int i = 0; i < req_log.size() && i < 4; i++)
            chk($sformatf("bp_addr%0d", i), req_log[i], 16'(2 * i));
        bus.inst_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("bp_valid%0d", k), 16'(bus.inst_valid), 16'd1);
            chk($sformatf("bp_inst%0d", k), bus.inst, 16'hA000 | 16'(2 * k));
            chk($sformatf("bp_pc%0d", k), bus.inst_pc, 16'(2 * k));
            chk($sformatf("bp_seq%0d", k), bus.inst_seq_pc, 16'(2 * k + 2));
            if (bus.imem_req && !seen) begin
                seen = 1'b1;
                chk("bp_resume_addr", bus.imem_addr, 16'h0008);
            end
            tick();
        end
        #1;
        chk("bp_drained", 16'(bus.inst_valid), 16'd0);
        chk("bp_resumed", 16'(seen), 16'd1);

        // redirect and ack in the same cycle with two entries queued
        do_reset();
        bus.inst_ready = 1'b0;
        serve(5);
        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = 16'h5555;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0200;
        #1;
        chk("rdack_valid_before", 16'(bus.inst_valid), 16'd1);
        chk("rdack_req_suppressed", 16'(bus.imem_req), 16'd0);
        tick();
        bus.imem_ack = 1'b0;
        bus.redirect = 1'b0;
        #1;
        chk("rdack_flushed", 16'(bus.inst_valid), 16'd0);
        chk("rdack_req", 16'(bus.imem_req), 16'd1);
        chk("rdack_addr", bus.imem_addr, 16'h0200);
        tick();

        // PC wrap on the second instance (RESET_PC = 0xFFFE)
        do_reset();
        #1;
        chk("wrap_addr0", bus2.imem_addr, 16'hFFFE);
        chk("wrap_req0", 16'(bus2.imem_req), 16'd1);
        tick();
        bus2.imem_ack = 1'b1;
        bus2.imem_rdata = 16'h7777;
        tick();
        bus2.imem_ack = 1'b0;
        #1;
        chk("wrap_addr1", bus2.imem_addr, 16'h0000);
        chk("wrap_valid", 16'(bus2.inst_valid), 16'd1);
        chk("wrap_inst", bus2.inst, 16'h7777);
        chk("wrap_pc", bus2.inst_pc, 16'hFFFE);
        chk("wrap_seq", bus2.inst_seq_pc, 16'h0000);
        tick();

        // async reset pulse mid-WAIT with one entry queued, then a late ack in IDLE
        do_reset();
        bus.inst_ready = 1'b0;
        serve(3);
        #1;
        chk("ar_valid_pre", 16'(bus.inst_valid), 16'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("ar_req_low", 16'(bus.imem_req), 16'd0);
        chk("ar_valid_low", 16'(bus.inst_valid), 16'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_restart_req", 16'(bus.imem_req), 16'd1);
        chk("ar_restart_addr", bus.imem_addr, 16'h0000);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 16'hBAD0;
        tick();
        bus.imem_ack = 1'b0;
        #1;
        chk("ar_late_ignored", 16'(bus.inst_valid), 16'd0);
        tick();
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 16'h1234;
        tick();
        bus.imem_ack = 1'b0;
        #1;
        chk("ar_first_valid", 16'(bus.inst_valid), 16'd1);
        chk("ar_first_inst", bus.inst, 16'h1234);
        chk("ar_first_pc", bus.inst_pc, 16'h0000);
        tick();

        // random traffic against a queue-level model
        do_reset();
        mq.delete();
        m_fpc = 16'h0000;
        m_opc = 16'h0000;
        m_out = 0;
        wcnt  = 0;
        for (int c = 0; c < 600; c++) begin
            bus.imem_ack    = pend && (wcnt == 0);
            bus.imem_rdata  = 16'($urandom);
            bus.redirect    = ($urandom_range(0, 11) == 0);
            bus.redirect_pc = 16'($urandom) & 16'hFFFE;
            bus.inst_ready  = ($urandom_range(0, 2) != 0);
            #1;
            e_req   = (m_out == 0) && (mq.size() < 4) && !bus.redirect;
            e_valid = (mq.size() != 0);
            chk("rnd_req", 16'(bus.imem_req), 16'(e_req));
            if (e_req) chk("rnd_addr", bus.imem_addr, m_fpc);
            chk("rnd_valid", 16'(bus.inst_valid), 16'(e_valid));
            if (e_valid) begin
                chk("rnd_inst", bus.inst, mq[0].inst);
                chk("rnd_pc", bus.inst_pc, mq[0].pc);
                chk("rnd_seq", bus.inst_seq_pc, mq[0].pc + 16'd2);
            end
            // 0: nothing outstanding, 1: live read, 2: read to be discarded
            if (bus.redirect) begin
                m_fpc = bus.redirect_pc;
                mq.delete();
                if (bus.imem_ack)  m_out = 0;
                else if (m_out == 1) m_out = 2;
            end else begin
                if (mq.size() != 0 && bus.inst_ready) void'(mq.pop_front());
                if (bus.imem_ack && m_out == 1) mq.push_back('{inst: bus.imem_rdata, pc: m_opc});
                if (bus.imem_ack) m_out = 0;
                if (e_req) begin
                    m_out = 1;
                    m_opc = m_fpc;
                    m_fpc = m_fpc + 16'd2;
                end
            end
            if (bus.imem_ack) pend = 1'b0;
            else if (pend) wcnt--;
            if (bus.imem_req) begin
                pend = 1'b1;
                wcnt = int'($urandom_range(0, 2));
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised next-generation fetch stage: owns the fetch PC and issues one instruction-memory read at a time over a req/ack handshake that tolerates variable latency.
- Returned instructions are buffered, with their PC and sequential PC, in a DEPTH-entry FIFO.
- The FIFO is drained by decode through a valid/ready handshake.
- A redirect (branch or jump) flushes the queue and discards any in-flight response.

Parameters:
- WIDTH, 16, instruction and PC width in bits.
- DEPTH, 4, FIFO entries (power of two, at least 2).
- INC, 2, sequential PC increment.
- RESET_PC, 0, fetch PC after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
- redirect  in  1  load redirect_pc into the fetch PC and flush.
- redirect_pc  in  WIDTH  redirect target.
- imem_req  out  1  read request, valid for one cycle.
- imem_addr  out  WIDTH  request address (the fetch PC).
- imem_ack  in  1  read data valid, at least 1 cycle after imem_req.
- imem_rdata  in  WIDTH  instruction returned with imem_ack.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decode accepts the head.
- inst  out  WIDTH  head instruction.
- inst_pc  out  WIDTH  address of the head instruction.
- inst_seq_pc  out  WIDTH  inst_pc + INC, modulo 2^WIDTH.

Behaviour:
- Reset (rst=0, asynchronous): fetch PC = RESET_PC; FIFO empty (count 0, pointers 0); state IDLE; req_pc = 0.
- During reset: imem_req = 0, inst_valid = 0; inst, inst_pc and inst_seq_pc are don't-care.
- Reset asserted mid-transaction abandons the outstanding request. An imem_ack arriving after reset release while in IDLE is ignored.
- State machine:
  - IDLE: imem_req = (count < DEPTH) && !redirect; imem_addr = fetch PC.
    - On issue: req_pc <= fetch PC; fetch PC <= fetch PC + INC (wraps modulo 2^WIDTH); go to WAIT.
  - WAIT: imem_req = 0.
    - imem_ack && !redirect: push {imem_rdata, req_pc}; go to IDLE.
    - imem_ack && redirect: discard the data; go to IDLE.
    - !imem_ack && redirect: go to DROP.
  - DROP: imem_req = 0. On imem_ack, discard the data and go to IDLE.
- Redirect:
  - Has priority over every other event in its cycle.
  - Fetch PC <= redirect_pc and the FIFO is flushed (count 0), including any push or pop in the same cycle.
  - In IDLE, no request is issued that cycle.
  - Repeated redirects while in DROP only update the fetch PC.
- Pop: occurs when inst_valid && inst_ready && !redirect.
  - inst_valid = (count != 0).
  - Outputs come from the FIFO head and are stable while inst_ready = 0.
- Push and pop in the same cycle: count is unchanged and both pointers advance. Read and write pointers wrap modulo DEPTH.
- Full (count == DEPTH): no issue. Overflow is impossible because at most one request is outstanding and issue requires count < DEPTH.
- Empty: inst_valid = 0; inst_ready is ignored.
- Latency, zero-wait memory (ack the cycle after req):
  - First instruction reaches inst_valid 2 cycles after the request.
  - Steady-state throughput is 1 instruction per 2 cycles.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: when the FIFO is empty and an accepted imem_ack (not discarded) arrives, imem_rdata/req_pc drive the outputs combinationally with inst_valid = 1 that cycle. If inst_ready = 1, nothing is pushed; otherwise the entry is pushed normally.
- Not defined: responses always go through the FIFO, so inst_valid rises the cycle after imem_ack.

Test Plan:
- Reset then sequential fetch, ack 1 cycle after each req, inst_ready = 1 -> imem_addr sequence 0x0000, 0x0002, 0x0004. Outputs inst_pc 0x0000 / inst_seq_pc 0x0002, then 0x0002 / 0x0004, in order, with matching imem_rdata values.
- Backpressure, inst_ready = 0, DEPTH = 4 -> exactly 4 requests issued, then imem_req stays 0. Raising inst_ready drains 4 entries in order, and fetching resumes at 0x0008.
- Redirect to 0x0100 while in WAIT, ack 3 cycles later with 0xDEAD -> 0xDEAD never appears on inst. The next imem_addr is 0x0100 and the FIFO is empty after the redirect.
- Redirect and imem_ack in the same cycle, with the FIFO holding 2 entries -> data discarded, inst_valid = 0 next cycle, next request at redirect_pc.
- Wrap-around: RESET_PC = 0xFFFE -> imem_addr 0xFFFE then 0x0000; the first entry has inst_seq_pc = 0x0000.
- Asynchronous reset pulse mid-WAIT, with no clock edge during the pulse -> imem_req = 0 and inst_valid = 0 immediately; after release, fetch restarts at RESET_PC and a late ack is ignored.
